// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle between the requesters and the round-robin mux arbiter.
// Handshake meaning: each REQ bit is a level request. The matching GNT bit
// goes high the cycle after REQ is sampled and stays high while that source
// owns the mux. VALID marks any active grant, and Y is meaningful only then.
interface mux4_rr_arbiter_if #(
    parameter int W = 1
);
    logic [3:0]   REQ;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [W-1:0] D;
    logic [3:0]   GNT;
    logic         S0;
    logic         S1;
    logic         VALID;
    logic [W-1:0] Y;

    // Requester side: drives requests and data, observes the grant and mux output.
    modport master (
        output REQ, A, B, C, D,
        input  GNT, S0, S1, VALID, Y
    );

    // Arbiter side.
    modport slave (
        input  REQ, A, B, C, D,
        output GNT, S0, S1, VALID, Y
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a 4:1 mux.
// A grant is held while its requester keeps REQ high. Under contention it is
// rotated after MAX_HOLD cycles. The mux itself is the combinational Y path.
module mux4_rr_arbiter #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                CLK,
    input  logic                RST,
    mux4_rr_arbiter_if.slave    bus,
    output logic                o_dbg_state,
    output logic [3:0]          o_dbg_hold
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_valid;
    logic [3:0] r_cnt;
    logic [1:0] r_ptr;

    logic [3:0] w_search;
    logic       w_any;
    logic [1:0] w_pick;
    logic       w_cur_req;

    // While busy, only the other requesters compete. The current owner is
    // handled by the hold rules instead. r_ptr always equals the current owner
    // while busy, so one search base serves both states.
    always_comb begin
        w_search = (r_state == BUSY) ? (bus.REQ & ~r_gnt) : bus.REQ;
        w_any    = |w_search;
        w_cur_req = bus.REQ[r_sel];
    end

    // Round-robin search starting one past the pointer, wrapping modulo 4.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        found  = 1'b0;
        w_pick = r_ptr;
        cand   = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = r_ptr + 2'(k);
            if (!found && w_search[cand]) begin
                found  = 1'b1;
                w_pick = cand;
            end
        end
    end

    // Arbitration FSM. All outputs are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'b00;
            r_valid <= 1'b0;
            r_cnt   <= 4'd0;
            r_ptr   <= 2'd3;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= BUSY;
                        r_gnt   <= 4'b0001 << w_pick;
                        r_sel   <= w_pick;
                        r_valid <= 1'b1;
                        r_cnt   <= 4'd1;
                        r_ptr   <= w_pick;
                    end
                end
                BUSY: begin
                    if (!w_cur_req) begin
                        if (w_any) begin
                            // Owner released with others waiting: hand over with no idle gap.
                            r_gnt <= 4'b0001 << w_pick;
                            r_sel <= w_pick;
                            r_cnt <= 4'd1;
                            r_ptr <= w_pick;
                        end else begin
                            // Owner released and nobody waits. S1/S0 keep their last value.
                            r_state <= IDLE;
                            r_gnt   <= 4'b0000;
                            r_valid <= 1'b0;
                            r_cnt   <= 4'd0;
                        end
                    end else if ((r_cnt == HOLD_MAX) && w_any) begin
                        // Hold budget used up while others wait: rotate.
                        r_gnt <= 4'b0001 << w_pick;
                        r_sel <= w_pick;
                        r_cnt <= 4'd1;
                        r_ptr <= w_pick;
                    end else if (r_cnt < HOLD_MAX) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Inline 4:1 mux driven by the registered selects, gated to 0 when idle.
    always_comb begin
        bus.Y = '0;
        if (r_valid) begin
            case (r_sel)
                2'd0:    bus.Y = bus.A;
                2'd1:    bus.Y = bus.B;
                2'd2:    bus.Y = bus.C;
                default: bus.Y = bus.D;
            endcase
        end
    end

    assign bus.GNT     = r_gnt;
    assign bus.S1      = r_sel[1];
    assign bus.S0      = r_sel[0];
    assign bus.VALID   = r_valid;
    assign o_dbg_state = r_state;
    assign o_dbg_hold  = r_cnt;
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath (inputs A, B, C, D) between four requesters.
- Sequences the S1/S0 select lines and grants ownership.
- Bounds each ownership to MAX_HOLD cycles while others wait.
- Sits in front of the 4:1 mux components as their controller; the mux function is instantiated inline.

Parameters:
- W, 1, data width of A/B/C/D/Y.
- MAX_HOLD, 4, max consecutive cycles a grant is held while another requester is pending. Legal range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D.
- A  input  W  source 0 data.
- B  input  W  source 1 data.
- C  input  W  source 2 data.
- D  input  W  source 3 data.
- GNT  output  4  one-hot grant, registered; 0000 when idle.
- S0  output  1  mux select LSB, registered.
- S1  output  1  mux select MSB, registered.
- VALID  output  1  high while any grant is active, registered.
- Y  output  W  selected data, combinational from registered S1/S0; forced 0 when VALID=0.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RST). RST dominates every other input.
- Reset values: GNT=0000, S1=0, S0=0, VALID=0, Y=0, state=IDLE, hold counter=0, last-grant pointer=3 (so index 0 has first priority).
- Select encoding: index = {S1,S0}. A=00, B=01 (S0=1), C=10 (S1=1), D=11. GNT is always one-hot of the index when VALID=1.
- Round-robin pick: search REQ starting at (ptr+1) mod 4 and wrapping; the first asserted bit wins. ptr is updated to the winner on every new grant.
- State IDLE:
  - REQ==0000 -> stay in IDLE, outputs unchanged (idle values).
  - Any REQ bit set -> on this edge register the winner into GNT/S1/S0, set VALID=1, counter=1, go to BUSY.
  - Latency: REQ sampled high at edge N gives GNT visible after edge N.
- State BUSY (cur = granted index), evaluated each edge in priority order:
  1. REQ[cur]=0 and another REQ set -> regrant immediately to the RR winner after cur, counter=1. No idle bubble.
  2. REQ[cur]=0 and no other REQ set -> go to IDLE. GNT=0000, VALID=0, S1/S0 hold last value.
  3. REQ[cur]=1, counter==MAX_HOLD, and another REQ set -> rotate to the RR winner after cur, counter=1.
  4. REQ[cur]=1 otherwise -> keep grant. Counter increments and saturates at MAX_HOLD. A sole requester keeps the grant indefinitely.
- Simultaneous requests are resolved only by the RR pointer; there is no fixed priority beyond the reset pointer.
- MAX_HOLD=1: under contention the grant rotates every cycle.
- Requests arriving mid-grant do not preempt before MAX_HOLD expires.
- RST mid-grant: after that edge all outputs take their reset values and ptr=3. The grant is lost and no completion is signalled.
- Counter width: 4 bits.

Test Plan:
- Reset: RST=1 for 2 edges with REQ=1111 -> GNT=0000, VALID=0, Y=0. After the first edge with RST=0: GNT=0001, S1S0=00, Y=A.
- Sole requester: REQ=0100, C=1, others 0 -> next edge GNT=0100, S1=1, S0=0, Y=1. Grant held for 12 cycles (no rotation past MAX_HOLD=4).
- Full contention: REQ=1111, MAX_HOLD=4 -> GNT sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again. {S1,S0} tracks 00, 01, 10, 11.
- Early release with pending: B granted, REQ=1010; drop REQ[1] on the 2nd grant cycle -> next edge GNT=1000, VALID stays 1 with no gap.
- Release to idle, then pointer fairness: D granted alone, drop REQ -> next edge GNT=0000, VALID=0, Y=0. Then REQ=1001 -> GNT=0001 (A wins after ptr=3).
- Reset mid-grant: C granted with counter=2, RST=1 one edge while REQ=1111 -> GNT=0000, VALID=0. After RST=0 the next grant is 0001.
